// File: rtl/ctrl_pipe_pkg.sv
// Shared opcode/funct encodings, ALU op codes and the control bundle layout
// used by the decoder and every EX/MEM/WB consumer of the control pipeline.
package ctrl_pipe_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned OP_W  = 6;

  localparam logic [OP_W-1:0] OP_SPECIAL = 6'h00;
  localparam logic [OP_W-1:0] OP_J       = 6'h02;
  localparam logic [OP_W-1:0] OP_JAL     = 6'h03;
  localparam logic [OP_W-1:0] OP_BEQ     = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE     = 6'h05;
  localparam logic [OP_W-1:0] OP_ADDIU   = 6'h09;
  localparam logic [OP_W-1:0] OP_ORI     = 6'h0D;
  localparam logic [OP_W-1:0] OP_LUI     = 6'h0F;
  localparam logic [OP_W-1:0] OP_LW      = 6'h23;
  localparam logic [OP_W-1:0] OP_SB      = 6'h28;
  localparam logic [OP_W-1:0] OP_SW      = 6'h2B;

  localparam logic [OP_W-1:0] FN_SLL  = 6'h00;
  localparam logic [OP_W-1:0] FN_SRA  = 6'h03;
  localparam logic [OP_W-1:0] FN_JR   = 6'h08;
  localparam logic [OP_W-1:0] FN_MFHI = 6'h10;
  localparam logic [OP_W-1:0] FN_MFLO = 6'h12;
  localparam logic [OP_W-1:0] FN_MULT = 6'h18;
  localparam logic [OP_W-1:0] FN_DIV  = 6'h1A;
  localparam logic [OP_W-1:0] FN_ADDU = 6'h21;
  localparam logic [OP_W-1:0] FN_SUBU = 6'h23;
  localparam logic [OP_W-1:0] FN_AND  = 6'h24;
  localparam logic [OP_W-1:0] FN_OR   = 6'h25;
  localparam logic [OP_W-1:0] FN_SLT  = 6'h2A;

  localparam logic [3:0] ALU_NONE = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_LUI  = 4'd8;
  localparam logic [3:0] ALU_MULT = 4'd9;
  localparam logic [3:0] ALU_DIV  = 4'd10;

  // Bit 0 (reg_write) is the LSB; consumers slice by field name.
  typedef struct packed {
    logic       is_muldiv;
    logic       jump_link;
    logic       jump_reg;
    logic       jump;
    logic       branch;
    logic       reg_dest;
    logic       alu_src;
    logic [3:0] alu_op;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
  } ctrl_t;

  localparam int unsigned CTRL_W = $bits(ctrl_t);

  typedef struct packed {
    logic             valid;
    ctrl_t            ctrl;
    logic [REG_W-1:0] dest;
  } stage_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational ID-stage decoder: control bundle, destination register and
// the operand/HI-LO usage flags needed by the hazard logic.
module ctrl_decode
  import ctrl_pipe_pkg::*;
(
  input  logic [OP_W-1:0]  opcode,
  input  logic [OP_W-1:0]  funct,
  input  logic [REG_W-1:0] rt,
  input  logic [REG_W-1:0] rd,
  output ctrl_t            ctrl,
  output logic [REG_W-1:0] dest,
  output logic             reads_rt,
  output logic             is_hilo_user
);

  always_comb begin
    ctrl         = '0;
    reads_rt     = 1'b0;
    is_hilo_user = 1'b0;
    unique case (opcode)
      OP_SPECIAL: begin
        reads_rt       = 1'b1;
        ctrl.reg_dest  = 1'b1;
        ctrl.reg_write = 1'b1;
        case (funct)
          FN_JR: begin
            ctrl.reg_write = 1'b0;
            ctrl.jump      = 1'b1;
            ctrl.jump_reg  = 1'b1;
          end
          FN_MULT, FN_DIV: begin
            ctrl.reg_write = 1'b0;
            ctrl.is_muldiv = 1'b1;
            ctrl.alu_op    = (funct == FN_MULT) ? ALU_MULT : ALU_DIV;
            is_hilo_user   = 1'b1;
          end
          FN_MFHI, FN_MFLO: is_hilo_user = 1'b1;
          FN_ADDU: ctrl.alu_op = ALU_ADD;
          FN_SUBU: ctrl.alu_op = ALU_SUB;
          FN_AND:  ctrl.alu_op = ALU_AND;
          FN_OR:   ctrl.alu_op = ALU_OR;
          FN_SLT:  ctrl.alu_op = ALU_SLT;
          FN_SLL: begin
            ctrl.alu_op  = ALU_SLL;
            ctrl.alu_src = 1'b1;
          end
          FN_SRA: begin
            ctrl.alu_op  = ALU_SRA;
            ctrl.alu_src = 1'b1;
          end
          default: ;
        endcase
      end
      OP_J: ctrl.jump = 1'b1;
      OP_JAL: begin
        ctrl.jump      = 1'b1;
        ctrl.jump_link = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        reads_rt    = 1'b1;
        ctrl.branch = 1'b1;
        ctrl.alu_op = ALU_SUB;
      end
      OP_ADDIU, OP_ORI, OP_LUI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = (opcode == OP_ADDIU) ? ALU_ADD :
                         (opcode == OP_ORI)   ? ALU_OR  : ALU_LUI;
      end
      OP_LW: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.alu_op     = ALU_ADD;
      end
      OP_SW, OP_SB: begin
        reads_rt       = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALU_ADD;
      end
      default: ;
    endcase
  end

  // JAL links into r31; non-writers report r0 so hazard checks ignore them.
  always_comb begin
    dest = '0;
    if (opcode == OP_JAL)  dest = REG_W'(31);
    else if (ctrl.reg_write) dest = ctrl.reg_dest ? rd : rt;
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Control pipeline: decodes the ID instruction, carries the bundle through
// NUM_STAGES registered stages, and generates load-use / HI-LO stalls.
module ctrl_pipe
  import ctrl_pipe_pkg::*;
#(
  parameter int unsigned NUM_STAGES = 3,
  parameter int unsigned MULDIV_LAT = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         id_valid,
  input  logic [5:0]                   id_opcode,
  input  logic [5:0]                   id_funct,
  input  logic [4:0]                   id_rs,
  input  logic [4:0]                   id_rt,
  input  logic [4:0]                   id_rd,
  input  logic                         flush,
  output logic                         id_stall,
  output logic                         muldiv_busy,
  output logic [NUM_STAGES-1:0]        stage_valid,
  output logic [NUM_STAGES*CTRL_W-1:0] stage_ctrl,
  output logic [NUM_STAGES*5-1:0]      stage_dest
);

  // Six bits so a latency of 32 is representable.
  localparam int unsigned CNT_W = 6;

  ctrl_t            dec_ctrl;
  logic [REG_W-1:0] dec_dest;
  logic             dec_reads_rt;
  logic             dec_hilo;

  stage_t           st_q [NUM_STAGES];
  stage_t           st_d [NUM_STAGES];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_use, hilo_haz, bubble;

  ctrl_decode u_decode (
    .opcode       (id_opcode),
    .funct        (id_funct),
    .rt           (id_rt),
    .rd           (id_rd),
    .ctrl         (dec_ctrl),
    .dest         (dec_dest),
    .reads_rt     (dec_reads_rt),
    .is_hilo_user (dec_hilo)
  );

  always_comb begin
    load_use = st_q[0].valid && st_q[0].ctrl.mem_to_reg && (st_q[0].dest != '0) && id_valid &&
               ((st_q[0].dest == id_rs) || (dec_reads_rt && (st_q[0].dest == id_rt)));
    hilo_haz = muldiv_busy && dec_hilo;
  end

  assign muldiv_busy = (cnt_q != '0);
  assign id_stall    = (load_use || hilo_haz) && !flush;
  assign bubble      = id_stall || flush;

  // Stage 0 takes ID or a bubble; later stages always advance.
  always_comb begin
    st_d[0] = bubble ? '0 : stage_t'{valid: id_valid, ctrl: dec_ctrl, dest: dec_dest};
    for (int unsigned k = 1; k < NUM_STAGES; k++) st_d[k] = st_q[k-1];
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!bubble && id_valid && dec_ctrl.is_muldiv) cnt_d = CNT_W'(MULDIV_LAT);
    else if (cnt_q != '0)                          cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) st_q[k] <= '0;
      else        st_q[k] <= st_d[k];
    end
    assign stage_valid[k]                   = st_q[k].valid;
    assign stage_ctrl[k*CTRL_W +: CTRL_W]   = st_q[k].ctrl;
    assign stage_dest[k*REG_W +: REG_W]     = st_q[k].dest;
  end

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: decode table, hand-written hazard/reset sequences and
// a randomized run against a cycle-indexed reference model.
module tb_ctrl_pipe;

  localparam int NS  = 5;
  localparam int LAT = 4;
  localparam int CW  = 14;

  localparam logic [13:0] B_RW = 14'h0001, B_MTR = 14'h0002, B_MW = 14'h0004;
  localparam logic [13:0] B_SRC = 14'h0080, B_RD = 14'h0100, B_BR = 14'h0200;
  localparam logic [13:0] B_J = 14'h0400, B_JR = 14'h0800, B_JL = 14'h1000, B_MD = 14'h2000;

  logic clk, rst_n, id_valid, flush, id_stall, muldiv_busy;
  logic [5:0] id_opcode, id_funct;
  logic [4:0] id_rs, id_rt, id_rd;
  logic [NS-1:0]    stage_valid;
  logic [NS*CW-1:0] stage_ctrl;
  logic [NS*5-1:0]  stage_dest;

  int n_cmp = 0;
  int n_bad = 0;

  ctrl_pipe #(.NUM_STAGES(NS), .MULDIV_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_funct(id_funct), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .flush(flush), .id_stall(id_stall), .muldiv_busy(muldiv_busy),
    .stage_valid(stage_valid), .stage_ctrl(stage_ctrl), .stage_dest(stage_dest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drv(input logic v, input logic [5:0] op, input logic [5:0] fn,
                     input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                     input logic fl);
    id_valid = v; id_opcode = op; id_funct = fn;
    id_rs = rs; id_rt = rt; id_rd = rd; flush = fl;
  endtask

  task automatic idle();
    drv(1'b0, 6'h3F, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [13:0] alu(input int a);
    return 14'(a) << 3;
  endfunction

  function automatic logic [13:0] sctrl(input int k);
    return stage_ctrl[k*CW +: CW];
  endfunction

  function automatic logic [4:0] sdest(input int k);
    return stage_dest[k*5 +: 5];
  endfunction

  // Reference decoder built from the decode rules.
  task automatic mdec(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rt,
                      input logic [4:0] rd, output logic [13:0] c, output logic [4:0] d,
                      output bit rrt, output bit hl);
    c = '0; rrt = 0; hl = 0;
    case (op)
      6'h00: begin
        rrt = 1; c = B_RD;
        if (fn == 6'h08) c |= B_J | B_JR;
        else if (fn == 6'h18 || fn == 6'h1A) begin
          c |= B_MD | alu(fn == 6'h18 ? 9 : 10); hl = 1;
        end else begin
          c |= B_RW;
          case (fn)
            6'h21: c |= alu(1);
            6'h23: c |= alu(2);
            6'h24: c |= alu(3);
            6'h25: c |= alu(4);
            6'h2A: c |= alu(5);
            6'h00: c |= B_SRC | alu(6);
            6'h03: c |= B_SRC | alu(7);
            6'h10, 6'h12: hl = 1;
            default: ;
          endcase
        end
      end
      6'h02: c = B_J;
      6'h03: c = B_J | B_JL | B_RW;
      6'h04, 6'h05: begin c = B_BR | alu(2); rrt = 1; end
      6'h09: c = B_RW | B_SRC | alu(1);
      6'h0D: c = B_RW | B_SRC | alu(4);
      6'h0F: c = B_RW | B_SRC | alu(8);
      6'h23: c = B_RW | B_MTR | B_SRC | alu(1);
      6'h28, 6'h2B: begin c = B_MW | B_SRC | alu(1); rrt = 1; end
      default: ;
    endcase
    if (op == 6'h03) d = 5'd31;
    else if (c[0])   d = c[8] ? rd : rt;
    else             d = 5'd0;
  endtask

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [13:0] c;
    logic [4:0]  d;
  } vec_t;

  typedef struct {
    bit          v;
    logic [13:0] c;
    logic [4:0]  d;
  } ment_t;

  logic [5:0] pool_op [16] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h23,
                               6'h23, 6'h09, 6'h2B, 6'h04, 6'h03, 6'h0F, 6'h3F, 6'h28};
  logic [5:0] pool_fn [16] = '{6'h21, 6'h12, 6'h10, 6'h18, 6'h1A, 6'h08, 6'h00, 6'h00,
                               6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

  initial begin
    vec_t        tv[$];
    ment_t       mq[$];
    ment_t       e;
    logic [13:0] c;
    logic [4:0]  d;
    bit          rrt, hl, lu, mbusy, mst, found;
    int          stalls, cyc, busy_end;
    logic [NS-1:0]    ev;
    logic [NS*CW-1:0] ec;
    logic [NS*5-1:0]  ed;

    rst_n = 1'b0;
    idle();
    #2;
    chk("reset_valid", 96'(stage_valid), 96'd0);
    chk("reset_ctrl", 96'(stage_ctrl), 96'd0);
    chk("reset_dest", 96'(stage_dest), 96'd0);
    chk("reset_busy", 96'(muldiv_busy), 96'd0);
    chk("reset_stall", 96'(id_stall), 96'd0);
    #10 rst_n = 1'b1;
    tick();

    // Decode sweep, rs=1 rt=2 rd=3; MULT last so HI/LO busy never stalls the table.
    tv.push_back('{"addu", 6'h00, 6'h21, B_RW | B_RD | alu(1), 5'd3});
    tv.push_back('{"subu", 6'h00, 6'h23, B_RW | B_RD | alu(2), 5'd3});
    tv.push_back('{"sll", 6'h00, 6'h00, B_RW | B_RD | B_SRC | alu(6), 5'd3});
    tv.push_back('{"sra", 6'h00, 6'h03, B_RW | B_RD | B_SRC | alu(7), 5'd3});
    tv.push_back('{"jr", 6'h00, 6'h08, B_RD | B_J | B_JR, 5'd0});
    tv.push_back('{"jal", 6'h03, 6'h00, B_RW | B_J | B_JL, 5'd31});
    tv.push_back('{"lw", 6'h23, 6'h00, B_RW | B_MTR | B_SRC | alu(1), 5'd2});
    tv.push_back('{"j", 6'h02, 6'h00, B_J, 5'd0});
    tv.push_back('{"beq", 6'h04, 6'h00, B_BR | alu(2), 5'd0});
    tv.push_back('{"bne", 6'h05, 6'h00, B_BR | alu(2), 5'd0});
    tv.push_back('{"addiu", 6'h09, 6'h00, B_RW | B_SRC | alu(1), 5'd2});
    tv.push_back('{"ori", 6'h0D, 6'h00, B_RW | B_SRC | alu(4), 5'd2});
    tv.push_back('{"lui", 6'h0F, 6'h00, B_RW | B_SRC | alu(8), 5'd2});
    tv.push_back('{"sw", 6'h2B, 6'h00, B_MW | B_SRC | alu(1), 5'd0});
    tv.push_back('{"sb", 6'h28, 6'h00, B_MW | B_SRC | alu(1), 5'd0});
    tv.push_back('{"mfhi", 6'h00, 6'h10, B_RW | B_RD, 5'd3});
    tv.push_back('{"mflo", 6'h00, 6'h12, B_RW | B_RD, 5'd3});
    tv.push_back('{"unknown_op", 6'h3F, 6'h00, 14'h0, 5'd0});
    tv.push_back('{"unknown_fn", 6'h00, 6'h3F, B_RW | B_RD, 5'd3});
    tv.push_back('{"mult", 6'h00, 6'h18, B_RD | B_MD | alu(9), 5'd0});
    foreach (tv[i]) begin
      drv(1'b1, tv[i].op, tv[i].fn, 5'd1, 5'd2, 5'd3, 1'b0);
      #1;
      chk({tv[i].name, "_stall"}, 96'(id_stall), 96'd0);
      tick();
      chk({tv[i].name, "_valid"}, 96'(stage_valid[0]), 96'd1);
      chk({tv[i].name, "_ctrl"}, 96'(sctrl(0)), 96'(tv[i].c));
      chk({tv[i].name, "_dest"}, 96'(sdest(0)), 96'(tv[i].d));
    end
    chk("mult_busy", 96'(muldiv_busy), 96'd1);
    idle();
    repeat (8) tick();
    chk("busy_drained", 96'(muldiv_busy), 96'd0);

    // Asynchronous reset with three ADDU in flight.
    repeat (3) begin
      drv(1'b1, 6'h00, 6'h21, 5'd1, 5'd2, 5'd3, 1'b0);
      tick();
    end
    chk("inflight_valid", 96'(stage_valid[2:0]), 96'd7);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 96'(stage_valid), 96'd0);
    chk("async_rst_ctrl", 96'(stage_ctrl), 96'd0);
    chk("async_rst_dest", 96'(stage_dest), 96'd0);
    chk("async_rst_stall", 96'(id_stall), 96'd0);
    #2 rst_n = 1'b1;
    tick();
    chk("post_rst_first", 96'(stage_valid), 96'd1);

    // Load-use: LW r8 then ADDU reading r8.
    idle(); tick();
    drv(1'b1, 6'h23, 6'h00, 5'd1, 5'd8, 5'd0, 1'b0);
    tick();
    drv(1'b1, 6'h00, 6'h21, 5'd8, 5'd9, 5'd10, 1'b0);
    #1;
    chk("lu_stall", 96'(id_stall), 96'd1);
    tick();
    chk("lu_bubble", 96'(stage_valid[1:0]), 96'd2);
    chk("lu_stall_clears", 96'(id_stall), 96'd0);
    tick();
    chk("lu_issue_valid", 96'(stage_valid[0]), 96'd1);
    chk("lu_issue_dest", 96'(sdest(0)), 96'd10);
    chk("lu_issue_ctrl", 96'(sctrl(0)), 96'(B_RW | B_RD | alu(1)));

    // No false hazards.
    idle(); tick();
    drv(1'b1, 6'h23, 6'h00, 5'd1, 5'd0, 5'd0, 1'b0); tick();
    drv(1'b1, 6'h00, 6'h21, 5'd0, 5'd0, 5'd4, 1'b0); #1;
    chk("lu_r0_nostall", 96'(id_stall), 96'd0);
    tick();
    drv(1'b1, 6'h23, 6'h00, 5'd1, 5'd8, 5'd0, 1'b0); tick();
    drv(1'b1, 6'h09, 6'h00, 5'd9, 5'd8, 5'd0, 1'b0); #1;
    chk("lu_addiu_nostall", 96'(id_stall), 96'd0);
    tick();

    // MULT then dependent MFLO.
    idle(); repeat (3) tick();
    drv(1'b1, 6'h00, 6'h18, 5'd1, 5'd2, 5'd0, 1'b0);
    tick();
    drv(1'b1, 6'h00, 6'h12, 5'd0, 5'd0, 5'd12, 1'b0);
    stalls = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (!id_stall) break;
      stalls++;
      tick();
    end
    chk("mflo_stall_cycles", 96'(stalls), 96'(LAT));
    tick();
    chk("mflo_issue_valid", 96'(stage_valid[0]), 96'd1);
    chk("mflo_issue_dest", 96'(sdest(0)), 96'd12);

    // Flush during a load-use stall.
    idle(); tick();
    drv(1'b1, 6'h23, 6'h00, 5'd1, 5'd8, 5'd0, 1'b0); tick();
    drv(1'b1, 6'h00, 6'h21, 5'd8, 5'd9, 5'd17, 1'b1); #1;
    chk("flush_stall", 96'(id_stall), 96'd0);
    tick();
    chk("flush_bubble", 96'({stage_valid[0], sdest(0)}), 96'd0);
    idle();
    found = 0;
    for (int i = 0; i < NS + 1; i++) begin
      for (int k = 0; k < NS; k++) if (stage_valid[k] && sdest(k) == 5'd17) found = 1;
      tick();
    end
    chk("flush_killed", 96'(found), 96'd0);

    // WB (stage NS-1) timing.
    drv(1'b1, 6'h00, 6'h21, 5'd1, 5'd2, 5'd21, 1'b0);
    tick();
    idle();
    repeat (3) tick();
    chk("wb_not_yet", 96'(stage_valid[NS-1]), 96'd0);
    tick();
    chk("wb_valid", 96'(stage_valid[NS-1]), 96'd1);
    chk("wb_dest", 96'(sdest(NS-1)), 96'd21);

    // Randomized run against the reference model.
    #3 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    mq.delete();
    for (int k = 0; k < NS; k++) mq.push_back('{0, 14'h0, 5'd0});
    cyc = 0; busy_end = 0; mst = 0;
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < NS; k++) begin
        ev[k] = mq[k].v; ec[k*CW +: CW] = mq[k].c; ed[k*5 +: 5] = mq[k].d;
      end
      mbusy = (cyc < busy_end);
      if (n % 10 == 0) begin
        chk("rnd_valid", 96'(stage_valid), 96'(ev));
        chk("rnd_ctrl", 96'(stage_ctrl), 96'(ec));
        chk("rnd_dest", 96'(stage_dest), 96'(ed));
        chk("rnd_busy", 96'(muldiv_busy), 96'(mbusy));
      end else if (stage_valid !== ev || stage_ctrl !== ec || stage_dest !== ed || muldiv_busy !== mbusy) begin
        chk("rnd_state", 96'({stage_valid, stage_dest, muldiv_busy}), 96'({ev, ed, mbusy}));
      end
      if (!mst) begin
        int p;
        p = $urandom_range(0, 15);
        drv(($urandom_range(0, 9) != 0), pool_op[p], pool_fn[p], 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'b0);
      end
      flush = ($urandom_range(0, 9) == 0);
      #1;
      mdec(id_opcode, id_funct, id_rt, id_rd, c, d, rrt, hl);
      lu  = mq[0].v && mq[0].c[1] && (mq[0].d != 0) && id_valid &&
            ((mq[0].d == id_rs) || (rrt && mq[0].d == id_rt));
      mst = (lu || (mbusy && hl)) && !flush;
      if (id_stall !== mst) chk("rnd_stall", 96'(id_stall), 96'(mst));
      else if (n % 10 == 0) chk("rnd_stall", 96'(id_stall), 96'(mst));
      e = (mst || flush) ? '{0, 14'h0, 5'd0} : '{id_valid, c, d};
      tick();
      cyc++;
      if (e.v && e.c[13]) busy_end = cyc + LAT;
      mq.push_front(e);
      void'(mq.pop_back());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
